// File: rtl/gb_if_pkg.sv
// Shared encodings for the GB-side off-chip interface bridge.
// No logic; state encoding, request field layout and width helpers.
// Imported by gb_if_bridge and if_beat_conv.
package gb_if_pkg;

   // Bridge FSM states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CMD  = 2'd1,
      ST_RD   = 2'd2,
      ST_WR   = 2'd3
   } state_t;

   // Request info layout: {type[2:0], dir}
   localparam int INFO_W   = 4;
   localparam int DIR_RD   = 0;   // dir bit: 1 = pad->GB read, 0 = GB->pad write
   localparam int TYPE_LSB = 1;
   localparam int TYPE_W   = 3;

   // Beat counter width; a single-beat word still keeps a 1-bit counter
   function automatic int beat_cnt_w(input int beats);
      return (beats > 1) ? $clog2(beats) : 1;
   endfunction

endpackage

// File: rtl/if_beat_conv.sv
// Word<->beat converter: serializes a loaded word LSB-first, or assembles beats into a word.
// Latency: one cycle from word load to first beat; one cycle from last beat to word full.
// Backpressure: full flag blocks new loads (write) and new beats (read) until drained/taken.
module if_beat_conv
   import gb_if_pkg::*;
#(
   parameter int PORT_WIDTH = 128,
   parameter int PAD_WIDTH  = 32
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   input  logic                  mode_rd,
   input  logic                  word_load,
   input  logic [PORT_WIDTH-1:0] word_in,
   input  logic                  beat_out_acc,
   input  logic                  beat_in_acc,
   input  logic [PAD_WIDTH-1:0]  beat_in,
   input  logic                  word_take,
   output logic                  full,
   output logic                  beat_last,
   output logic [PAD_WIDTH-1:0]  beat_out,
   output logic [PORT_WIDTH-1:0] word_out
);

   localparam int R   = PORT_WIDTH / PAD_WIDTH;
   localparam int BCW = beat_cnt_w(R);
   localparam logic [BCW-1:0] LAST_BEAT = BCW'(R - 1);

   logic [PORT_WIDTH-1:0] data_q;
   logic                  full_q;
   logic [BCW-1:0]        beat_cnt;

   assign full      = full_q;
   assign beat_last = (beat_cnt == LAST_BEAT);
   assign beat_out  = data_q[PAD_WIDTH-1:0];
   assign word_out  = data_q;

   // Shared shift/assemble register; mode picks serialize (write) or assemble (read)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q   <= '0;
         full_q   <= 1'b0;
         beat_cnt <= '0;
      end else if (clr) begin
         data_q   <= '0;
         full_q   <= 1'b0;
         beat_cnt <= '0;
      end else if (mode_rd) begin
         if (word_take) begin
            full_q <= 1'b0;
         end else if (beat_in_acc) begin
            for (int s = 0; s < R; s++) begin
               if (beat_cnt == BCW'(s))
                  data_q[s*PAD_WIDTH +: PAD_WIDTH] <= beat_in;
            end
            if (beat_last) begin
               full_q   <= 1'b1;
               beat_cnt <= '0;
            end else begin
               beat_cnt <= beat_cnt + BCW'(1);
            end
         end
      end else begin
         if (word_load) begin
            data_q   <= word_in;
            full_q   <= 1'b1;
            beat_cnt <= '0;
         end else if (beat_out_acc) begin
            data_q <= data_q >> PAD_WIDTH;
            if (beat_last) begin
               full_q   <= 1'b0;
               beat_cnt <= '0;
            end else begin
               beat_cnt <= beat_cnt + BCW'(1);
            end
         end
      end
   end

endmodule

// File: rtl/gb_if_bridge.sv
// GB-side off-chip bridge: one request -> command beat -> BURST_LEN words over the pad bus.
// Latency: cmd beat the cycle after request accept; write beats start the cycle after word load.
// Backpressure: all ports val/rdy; payload held until accepted; soft_clr aborts to IDLE.
module gb_if_bridge
   import gb_if_pkg::*;
#(
   parameter int PORT_WIDTH = 128,
   parameter int PAD_WIDTH  = 32,
   parameter int BURST_LEN  = 16
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  soft_clr,
   input  logic                  GBIF_cfg_val,
   output logic                  IFGB_cfg_rdy,
   input  logic [INFO_W-1:0]     GBIF_cfg_info,
   input  logic                  GBIF_wr_val,
   output logic                  IFGB_wr_rdy,
   input  logic [PORT_WIDTH-1:0] GBIF_wr_data,
   output logic                  IFGB_rd_val,
   input  logic                  GBIF_rd_rdy,
   output logic [PORT_WIDTH-1:0] IFGB_rd_data,
   output logic                  IFPAD_cmd_val,
   input  logic                  PADIF_cmd_rdy,
   output logic [INFO_W-1:0]     IFPAD_cmd,
   output logic                  IFPAD_dat_val,
   input  logic                  PADIF_dat_rdy,
   output logic [PAD_WIDTH-1:0]  IFPAD_dat,
   input  logic                  PADIF_dat_val,
   output logic                  IFPAD_dat_rdy,
   input  logic [PAD_WIDTH-1:0]  PADIF_dat,
   output logic                  IF_busy
);

   localparam int WCW = $clog2(BURST_LEN + 1);
   localparam logic [WCW-1:0] WORD_LAST = WCW'(BURST_LEN - 1);
   localparam logic [WCW-1:0] WORD_MAX  = WCW'(BURST_LEN);

   state_t                state_q, state_d;
   logic [INFO_W-1:0]     cmd_q;
   logic [WCW-1:0]        word_cnt;

   logic                  cfg_fire, cmd_fire;
   logic                  wr_load, beat_out_acc, beat_in_acc, rd_take, word_done;
   logic                  conv_clr, conv_full, conv_beat_last;
   logic [PAD_WIDTH-1:0]  conv_beat;
   logic [PORT_WIDTH-1:0] conv_word;

   // Handshake decode; all rdy/val outputs come from registered state only
   assign IFGB_cfg_rdy  = (state_q == ST_IDLE);
   assign cfg_fire      = GBIF_cfg_val & IFGB_cfg_rdy & ~soft_clr;
   assign IFPAD_cmd_val = (state_q == ST_CMD);
   assign IFPAD_cmd     = cmd_q;
   assign cmd_fire      = IFPAD_cmd_val & PADIF_cmd_rdy;

   assign IFGB_wr_rdy   = (state_q == ST_WR) & ~conv_full;
   assign IFPAD_dat_val = (state_q == ST_WR) &  conv_full;
   assign IFPAD_dat     = IFPAD_dat_val ? conv_beat : '0;
   assign IFPAD_dat_rdy = (state_q == ST_RD) & ~conv_full;
   assign IFGB_rd_val   = (state_q == ST_RD) &  conv_full;
   assign IFGB_rd_data  = IFGB_rd_val ? conv_word : '0;
   assign IF_busy       = (state_q != ST_IDLE);

   assign wr_load      = GBIF_wr_val   & IFGB_wr_rdy;
   assign beat_out_acc = IFPAD_dat_val & PADIF_dat_rdy;
   assign beat_in_acc  = PADIF_dat_val & IFPAD_dat_rdy;
   assign rd_take      = IFGB_rd_val   & GBIF_rd_rdy;
   assign word_done    = (beat_out_acc & conv_beat_last) | rd_take;

   // Converter restarts at beat 0 on abort and at the start of every burst
   assign conv_clr = soft_clr | cmd_fire;

   if_beat_conv #(
      .PORT_WIDTH (PORT_WIDTH),
      .PAD_WIDTH  (PAD_WIDTH)
   ) u_conv (
      .clk          (clk),
      .rst_n        (rst_n),
      .clr          (conv_clr),
      .mode_rd      (state_q == ST_RD),
      .word_load    (wr_load),
      .word_in      (GBIF_wr_data),
      .beat_out_acc (beat_out_acc),
      .beat_in_acc  (beat_in_acc),
      .beat_in      (PADIF_dat),
      .word_take    (rd_take),
      .full         (conv_full),
      .beat_last    (conv_beat_last),
      .beat_out     (conv_beat),
      .word_out     (conv_word)
   );

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // FSM next state; soft_clr overrides every transition
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (cfg_fire) state_d = ST_CMD;
         ST_CMD:  if (cmd_fire) state_d = cmd_q[DIR_RD] ? ST_RD : ST_WR;
         ST_RD,
         ST_WR:   if (word_done && (word_cnt == WORD_LAST)) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      if (soft_clr) state_d = ST_IDLE;
   end

   // Request latch; a request seen under soft_clr is dropped
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        cmd_q <= '0;
      else if (cfg_fire) cmd_q <= GBIF_cfg_info;
   end

   // Completed-word counter for the current burst; saturates at BURST_LEN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         word_cnt <= '0;
      else if (soft_clr || cmd_fire)
         word_cnt <= '0;
      else if (word_done && (word_cnt != WORD_MAX))
         word_cnt <= word_cnt + WCW'(1);
   end

endmodule

// File: tb/tb_gb_if_bridge.sv
// Directed + randomized bench for gb_if_bridge with a word/beat slicing reference model.
// Latency: checks are sampled 1 time unit after each rising edge.
// Backpressure: random pad/GB ready and valid gaps, forced stalls, soft_clr and reset aborts.
module tb_gb_if_bridge;

   localparam int PW = 128;
   localparam int DW = 32;
   localparam int BL = 2;
   localparam int R  = PW / DW;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          soft_clr;
   logic          GBIF_cfg_val;
   logic          IFGB_cfg_rdy;
   logic [3:0]    GBIF_cfg_info;
   logic          GBIF_wr_val;
   logic          IFGB_wr_rdy;
   logic [PW-1:0] GBIF_wr_data;
   logic          IFGB_rd_val;
   logic          GBIF_rd_rdy;
   logic [PW-1:0] IFGB_rd_data;
   logic          IFPAD_cmd_val;
   logic          PADIF_cmd_rdy;
   logic [3:0]    IFPAD_cmd;
   logic          IFPAD_dat_val;
   logic          PADIF_dat_rdy;
   logic [DW-1:0] IFPAD_dat;
   logic          PADIF_dat_val;
   logic          IFPAD_dat_rdy;
   logic [DW-1:0] PADIF_dat;
   logic          IF_busy;

   int vectors     = 0;
   int miscompares = 0;

   gb_if_bridge #(.PORT_WIDTH(PW), .PAD_WIDTH(DW), .BURST_LEN(BL)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .soft_clr      (soft_clr),
      .GBIF_cfg_val  (GBIF_cfg_val),
      .IFGB_cfg_rdy  (IFGB_cfg_rdy),
      .GBIF_cfg_info (GBIF_cfg_info),
      .GBIF_wr_val   (GBIF_wr_val),
      .IFGB_wr_rdy   (IFGB_wr_rdy),
      .GBIF_wr_data  (GBIF_wr_data),
      .IFGB_rd_val   (IFGB_rd_val),
      .GBIF_rd_rdy   (GBIF_rd_rdy),
      .IFGB_rd_data  (IFGB_rd_data),
      .IFPAD_cmd_val (IFPAD_cmd_val),
      .PADIF_cmd_rdy (PADIF_cmd_rdy),
      .IFPAD_cmd     (IFPAD_cmd),
      .IFPAD_dat_val (IFPAD_dat_val),
      .PADIF_dat_rdy (PADIF_dat_rdy),
      .IFPAD_dat     (IFPAD_dat),
      .PADIF_dat_val (PADIF_dat_val),
      .IFPAD_dat_rdy (IFPAD_dat_rdy),
      .PADIF_dat     (PADIF_dat),
      .IF_busy       (IF_busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_cfg_rdy"}, IFGB_cfg_rdy, 1);
      chk({tag, "_busy"},    IF_busy, 0);
      chk({tag, "_quiet"},   {IFPAD_cmd_val, IFPAD_dat_val, IFPAD_dat_rdy, IFGB_wr_rdy, IFGB_rd_val}, 0);
   endtask

   task automatic do_cmd(input logic [3:0] info, input int stall);
      int n = 0;
      GBIF_cfg_val  = 1'b1;
      GBIF_cfg_info = info;
      while (!IFGB_cfg_rdy && n < 20) begin tick(); n++; end
      chk("cfg_rdy_wait", IFGB_cfg_rdy, 1);
      tick();
      GBIF_cfg_val  = 1'b0;
      GBIF_cfg_info = 4'($urandom);
      for (int i = 0; i < stall; i++) begin
         PADIF_cmd_rdy = 1'b0;
         chk("cmd_val_held", IFPAD_cmd_val, 1);
         chk("cmd_stable",   IFPAD_cmd, info);
         chk("cmd_no_data",  {IFPAD_dat_val, IFGB_wr_rdy, IFPAD_dat_rdy, IFGB_rd_val}, 0);
         tick();
      end
      PADIF_cmd_rdy = 1'b1;
      chk("cmd_val", IFPAD_cmd_val, 1);
      chk("cmd",     IFPAD_cmd, info);
      tick();
      PADIF_cmd_rdy = 1'b0;
   endtask

   // abort_kind: 0 = run to completion, 1 = soft_clr, 2 = async reset; taken once abort_at beats moved
   task automatic run_burst(input logic [3:0] info, input int stall, input int abort_kind,
                            input int abort_at, input bit directed);
      logic [PW-1:0] words [BL];
      logic [DW-1:0] beats [BL*R];
      logic [DW-1:0] last_dat;
      logic [PW-1:0] last_rd;
      bit            fire_w, fire_p, stalled_pad, stalled_gb, aborted;
      int            wi, bi, lo_rd;

      for (int w = 0; w < BL; w++) words[w] = {$urandom, $urandom, $urandom, $urandom};
      if (directed) words[0] = info[0] ? {32'd4, 32'd3, 32'd2, 32'd1}
                                       : 128'hFFEEDDCC_BBAA9988_77665544_33221100;
      for (int b = 0; b < BL*R; b++) beats[b] = words[b / R][(b % R)*DW +: DW];

      do_cmd(info, stall);
      wi = 0; bi = 0; lo_rd = 5; aborted = 0;
      fire_w = 0; fire_p = 0; stalled_pad = 0; stalled_gb = 0;
      last_dat = '0; last_rd = '0;

      for (int cyc = 0; cyc < 400 && !(wi == BL && bi == BL*R); cyc++) begin
         if (abort_kind != 0 && bi == abort_at) begin aborted = 1; break; end
         chk("busy_in_burst", IF_busy, 1);
         if (!info[0]) begin
            if (fire_w) GBIF_wr_val = 1'b0;
            if (!GBIF_wr_val && wi < BL) GBIF_wr_val = ($urandom_range(0, 2) != 0);
            GBIF_wr_data  = GBIF_wr_val ? words[wi] : '0;
            PADIF_dat_rdy = ($urandom_range(0, 2) != 0);
            chk("wr_no_rd_side", {IFGB_rd_val, IFPAD_dat_rdy}, 0);
            if (stalled_pad) begin
               chk("wr_val_held",    IFPAD_dat_val, 1);
               chk("wr_beat_stable", IFPAD_dat, last_dat);
            end
            if (IFPAD_dat_val && PADIF_dat_rdy) begin
               if (bi < BL*R) chk("wr_beat", IFPAD_dat, beats[bi]);
               else           chk("wr_extra_beat", IFPAD_dat_val, 0);
               bi++;
            end
            stalled_pad = IFPAD_dat_val && !PADIF_dat_rdy;
            last_dat    = IFPAD_dat;
            fire_w      = GBIF_wr_val && IFGB_wr_rdy;
            if (fire_w) wi++;
         end else begin
            if (fire_p) PADIF_dat_val = 1'b0;
            if (!PADIF_dat_val && bi < BL*R) PADIF_dat_val = ($urandom_range(0, 3) != 0);
            PADIF_dat = PADIF_dat_val ? beats[bi] : '0;
            if (lo_rd > 0) begin
               GBIF_rd_rdy = 1'b0;
               if (IFGB_rd_val) lo_rd--;
            end else begin
               GBIF_rd_rdy = ($urandom_range(0, 1) != 0);
            end
            chk("rd_no_wr_side", {IFPAD_dat_val, IFGB_wr_rdy}, 0);
            if (IFGB_rd_val) chk("rd_full_blocks_beat", IFPAD_dat_rdy, 0);
            if (stalled_gb) begin
               chk("rd_val_held",    IFGB_rd_val, 1);
               chk("rd_word_stable", IFGB_rd_data, last_rd);
            end
            if (IFGB_rd_val && GBIF_rd_rdy) begin
               if (wi < BL) chk("rd_word", IFGB_rd_data, words[wi]);
               else         chk("rd_extra_word", IFGB_rd_val, 0);
               wi++;
            end
            stalled_gb = IFGB_rd_val && !GBIF_rd_rdy;
            last_rd    = IFGB_rd_data;
            fire_p     = PADIF_dat_val && IFPAD_dat_rdy;
            if (fire_p) bi++;
         end
         tick();
      end

      GBIF_wr_val = 1'b0; PADIF_dat_val = 1'b0; GBIF_rd_rdy = 1'b0; PADIF_dat_rdy = 1'b0;

      if (aborted && abort_kind == 1) begin
         soft_clr = 1'b1;
         tick();
         chk_idle("softclr");
         chk("softclr_dat_val", IFPAD_dat_val, 0);
         GBIF_cfg_val  = 1'b1;
         GBIF_cfg_info = info;
         tick();
         chk("softclr_req_dropped", IF_busy, 0);
         soft_clr     = 1'b0;
         GBIF_cfg_val = 1'b0;
      end else if (aborted && abort_kind == 2) begin
         #3 rst_n = 1'b0;
         #1;
         chk("arst_busy",    IF_busy, 0);
         chk("arst_rd_side", {IFGB_rd_val, IFPAD_dat_rdy, IFPAD_cmd_val, IFPAD_dat_val, IFGB_wr_rdy}, 0);
         chk("arst_rd_data", IFGB_rd_data, 0);
         chk("arst_cmd",     IFPAD_cmd, 0);
         @(posedge clk);
         #3 rst_n = 1'b1;
         tick();
         chk_idle("arst_release");
      end else begin
         chk("burst_words", wi, BL);
         chk("burst_beats", bi, BL*R);
         chk_idle("burst_end");
      end
   endtask

   initial begin
      rst_n = 1'b0; soft_clr = 1'b0;
      GBIF_cfg_val = 1'b0; GBIF_cfg_info = '0;
      GBIF_wr_val = 1'b0; GBIF_wr_data = '0; GBIF_rd_rdy = 1'b0;
      PADIF_cmd_rdy = 1'b0; PADIF_dat_rdy = 1'b0; PADIF_dat_val = 1'b0; PADIF_dat = '0;
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;
      tick();

      // Reset state
      chk_idle("reset");
      chk("reset_cmd",     IFPAD_cmd, 0);
      chk("reset_dat",     IFPAD_dat, 0);
      chk("reset_rd_data", IFGB_rd_data, 0);

      // Directed write and read bursts
      run_burst(4'b0010, 0, 0, 0, 1'b1);
      run_burst(4'b0111, 0, 0, 0, 1'b1);

      // Command stall of 3 cycles
      run_burst({3'($urandom), 1'b0}, 3, 0, 0, 1'b0);

      // Random back-to-back bursts
      for (int k = 0; k < 6; k++)
         run_burst(4'($urandom), $urandom_range(0, 2), 0, 0, 1'b0);

      // soft_clr after beat 2 of word 1, then a fresh write
      run_burst({3'($urandom), 1'b0}, 0, 1, R + 3, 1'b0);
      run_burst({3'($urandom), 1'b0}, 0, 0, 0, 1'b0);

      // Async reset mid-read, then a fresh read
      run_burst({3'($urandom), 1'b1}, 0, 2, 6, 1'b0);
      run_burst({3'($urandom), 1'b1}, 1, 0, 0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
